// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//   NUM_REGS x DATA_WIDTH register file with one write port, two independent
//   registered read ports (write-first forwarding), and a dump engine that
//   streams every register out in ascending order over a valid/ready link.
//
// Ports
//   clock       : sole clock, all state updates on the rising edge
//   reset       : synchronous, active-high reset
//   wr_en       : write strobe
//   wr_addr     : write address
//   wr_data     : write data
//   rd_addr_a   : read port A address
//   rd_data_a   : read port A data, one cycle after its address
//   rd_addr_b   : read port B address
//   rd_data_b   : read port B data, one cycle after its address
//   dump_start  : request a sequential readout of all registers
//   dump_busy   : high while a dump is in progress
//   dump_valid  : a dump beat is presented
//   dump_ready  : consumer accepts the current beat
//   dump_addr   : index of the current beat
//   dump_data   : contents captured for the current beat
// ---------------------------------------------------------------------------
module register_file #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_REGS    = 8,
    parameter int ADDR_WIDTH  = 3,
    parameter int RESET_VALUE = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    input  logic                  dump_start,
    output logic                  dump_busy,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [ADDR_WIDTH-1:0] dump_addr,
    output logic [DATA_WIDTH-1:0] dump_data
);

    localparam logic [DATA_WIDTH-1:0] RST_VAL  = DATA_WIDTH'(RESET_VALUE);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Storage. Every register is reset, so this maps to fabric flops rather
    // than a block RAM.
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] reg_mem [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_sel;

    // One-hot write decode, one select line per register.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en && (wr_addr == ADDR_WIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reset) begin
                reg_mem[i] <= RST_VAL;
            end else if (wr_sel[i]) begin
                reg_mem[i] <= wr_data;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read ports. A write to the address being read in the same cycle is
    // forwarded so the reader sees the new value (write-first).
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rd_fwd_a;
    logic [DATA_WIDTH-1:0] rd_fwd_b;
    logic [DATA_WIDTH-1:0] rd_data_a_reg;
    logic [DATA_WIDTH-1:0] rd_data_b_reg;

    assign rd_fwd_a = (wr_en && (wr_addr == rd_addr_a)) ? wr_data : reg_mem[rd_addr_a];
    assign rd_fwd_b = (wr_en && (wr_addr == rd_addr_b)) ? wr_data : reg_mem[rd_addr_b];

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_a_reg <= '0;
            rd_data_b_reg <= '0;
        end else begin
            rd_data_a_reg <= rd_fwd_a;
            rd_data_b_reg <= rd_fwd_b;
        end
    end

    assign rd_data_a = rd_data_a_reg;
    assign rd_data_b = rd_data_b_reg;

    // -----------------------------------------------------------------------
    // Dump engine
    // -----------------------------------------------------------------------
    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] idx_reg, idx_next;
    logic [DATA_WIDTH-1:0] dump_data_reg, dump_data_next;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0] cap_data;

    // The register captured on the next load: reg[0] when starting, otherwise
    // the one after the beat being handed over. On the final beat this wraps
    // to 0 but is never loaded.
    assign cap_addr = (state_reg == SEND) ? (idx_reg + ADDR_WIDTH'(1)) : '0;
    assign cap_data = (wr_en && (wr_addr == cap_addr)) ? wr_data : reg_mem[cap_addr];

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            dump_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            dump_data_reg <= dump_data_next;
        end
    end

    // Next-state logic. The captured beat is only replaced on a transfer, so
    // a stalled beat stays frozen even if its register is rewritten.
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        dump_data_next = dump_data_reg;
        unique case (state_reg)
            IDLE: begin
                if (dump_start) begin
                    state_next     = SEND;
                    idx_next       = '0;
                    dump_data_next = cap_data;
                end
            end
            SEND: begin
                if (dump_ready) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next       = idx_reg + ADDR_WIDTH'(1);
                        dump_data_next = cap_data;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        dump_busy  = (state_reg == SEND);
        dump_valid = (state_reg == SEND);
        dump_addr  = idx_reg;
        dump_data  = dump_data_reg;
    end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

    logic        clock = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  rd_addr_a;
    logic [15:0] rd_data_a;
    logic [2:0]  rd_addr_b;
    logic [15:0] rd_data_b;
    logic        dump_start;
    logic        dump_busy;
    logic        dump_valid;
    logic        dump_ready;
    logic [2:0]  dump_addr;
    logic [15:0] dump_data;

    int errors = 0;
    int checks = 0;

    // Scoreboard queues
    logic [15:0] exp_a [$];
    logic [15:0] exp_b [$];
    logic [18:0] exp_d [$];   // {addr, data}

    logic        rd_chk_a = 1'b0;
    logic        rd_chk_b = 1'b0;
    logic        chk_a_d  = 1'b0;
    logic        chk_b_d  = 1'b0;
    logic [15:0] mdl [8];
    logic [15:0] pop_v;
    logic [18:0] pop_d;

    always #5 clock = ~clock;

    register_file #(
        .DATA_WIDTH (16),
        .NUM_REGS   (8),
        .ADDR_WIDTH (3),
        .RESET_VALUE(0)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .dump_start(dump_start),
        .dump_busy (dump_busy),
        .dump_valid(dump_valid),
        .dump_ready(dump_ready),
        .dump_addr (dump_addr),
        .dump_data (dump_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Read checks fire one cycle after the address was issued.
    always @(posedge clock) begin
        chk_a_d <= rd_chk_a;
        chk_b_d <= rd_chk_b;
    end

    // Monitor: pops expected values whenever the DUT presents a response.
    always @(negedge clock) begin
        if (chk_a_d) begin
            if (exp_a.size() == 0) begin
                check("rd_a_unexpected", 32'(rd_data_a), 32'hFFFF_FFFF);
            end else begin
                pop_v = exp_a.pop_front();
                check("rd_a", 32'(rd_data_a), 32'(pop_v));
            end
        end
        if (chk_b_d) begin
            if (exp_b.size() == 0) begin
                check("rd_b_unexpected", 32'(rd_data_b), 32'hFFFF_FFFF);
            end else begin
                pop_v = exp_b.pop_front();
                check("rd_b", 32'(rd_data_b), 32'(pop_v));
            end
        end
        if (dump_valid) begin
            if (exp_d.size() == 0) begin
                check("dump_stray_beat", {13'd0, dump_addr, dump_data}, 32'hFFFF_FFFF);
            end else begin
                pop_d = exp_d.pop_front();
                check("dump_beat", {13'd0, dump_addr, dump_data}, {13'd0, pop_d});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cycle(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                         input logic [2:0] ra, input logic ca,
                         input logic [2:0] rb, input logic cb);
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        rd_addr_a = ra;
        rd_addr_b = rb;
        rd_chk_a  = ca;
        rd_chk_b  = cb;
        if (ca) exp_a.push_back((we && wa == ra) ? wd : mdl[ra]);
        if (cb) exp_b.push_back((we && wa == rb) ? wd : mdl[rb]);
        if (we) mdl[wa] = wd;
        tick();
        wr_en    = 1'b0;
        rd_chk_a = 1'b0;
        rd_chk_b = 1'b0;
    endtask

    task automatic push_beat(input int a, input logic [15:0] d);
        exp_d.push_back({3'(a), d});
    endtask

    initial begin
        reset      = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        rd_addr_a  = '0;
        rd_addr_b  = '0;
        dump_start = 1'b0;
        dump_ready = 1'b0;
        for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
        tick();
        tick();
        check("rst_rd_a", 32'(rd_data_a), 32'h0);
        check("rst_rd_b", 32'(rd_data_b), 32'h0);
        check("rst_valid", 32'(dump_valid), 32'h0);
        check("rst_busy", 32'(dump_busy), 32'h0);
        check("rst_addr", 32'(dump_addr), 32'h0);
        check("rst_data", 32'(dump_data), 32'h0);
        reset = 1'b0;

        // All registers read zero on both ports; dump_ready in IDLE is ignored.
        dump_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle(1'b0, 3'd0, 16'h0, 3'(i), 1'b1, 3'(7 - i), 1'b1);
        dump_ready = 1'b0;

        // Write-first forwarding, later read on port B, disabled write ignored.
        cycle(1'b1, 3'd5, 16'hBEEF, 3'd5, 1'b1, 3'd0, 1'b0);
        cycle(1'b0, 3'd5, 16'h1234, 3'd0, 1'b0, 3'd5, 1'b1);
        cycle(1'b0, 3'd5, 16'h1234, 3'd5, 1'b1, 3'd5, 1'b1);
        cycle(1'b1, 3'd2, 16'h5A5A, 3'd5, 1'b1, 3'd2, 1'b1);

        // Fill reg[i] = 0x1000+i, then read each on both ports at once.
        for (int i = 0; i < 8; i++) cycle(1'b1, 3'(i), 16'h1000 + 16'(i), 3'd0, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 3'd0, 16'h0, 3'(i), 1'b1, 3'(i), 1'b1);

        // Dump with dump_ready held high: 8 back-to-back beats.
        for (int i = 0; i < 8; i++) push_beat(i, 16'h1000 + 16'(i));
        dump_ready = 1'b1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        repeat (8) tick();
        check("dump1_busy_end", 32'(dump_busy), 32'h0);
        check("dump1_valid_end", 32'(dump_valid), 32'h0);
        check("dump1_all_beats", 32'(exp_d.size()), 32'h0);

        // Stall beat 3 for 4 cycles while rewriting reg 3.
        for (int i = 0; i < 3; i++) push_beat(i, 16'h1000 + 16'(i));
        repeat (5) push_beat(3, 16'h1003);
        for (int i = 4; i < 8; i++) push_beat(i, 16'h1000 + 16'(i));
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        repeat (3) tick();
        dump_ready = 1'b0;
        wr_en      = 1'b1;
        wr_addr    = 3'd3;
        wr_data    = 16'hAAAA;
        mdl[3]     = 16'hAAAA;
        tick();
        wr_en = 1'b0;
        repeat (3) tick();
        dump_ready = 1'b1;
        repeat (5) tick();
        check("dump2_busy_end", 32'(dump_busy), 32'h0);
        check("dump2_all_beats", 32'(exp_d.size()), 32'h0);

        // dump_start during SEND is ignored: still exactly 8 beats.
        for (int i = 0; i < 8; i++) push_beat(i, (i == 3) ? 16'hAAAA : 16'h1000 + 16'(i));
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        repeat (2) tick();
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        repeat (5) tick();
        check("dump3_busy_end", 32'(dump_busy), 32'h0);
        repeat (3) tick();
        check("dump3_no_restart", 32'(exp_d.size()), 32'h0);

        // Reset at beat 4 aborts the dump and wins over wr_en / dump_start.
        for (int i = 0; i < 5; i++) push_beat(i, (i == 3) ? 16'hAAAA : 16'h1000 + 16'(i));
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        repeat (4) tick();
        reset      = 1'b1;
        wr_en      = 1'b1;
        wr_addr    = 3'd2;
        wr_data    = 16'h5555;
        dump_start = 1'b1;
        tick();
        reset      = 1'b0;
        wr_en      = 1'b0;
        dump_start = 1'b0;
        for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
        check("rst_abort_valid", 32'(dump_valid), 32'h0);
        check("rst_abort_busy", 32'(dump_busy), 32'h0);
        check("rst_abort_addr", 32'(dump_addr), 32'h0);
        check("rst_abort_data", 32'(dump_data), 32'h0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 3'd0, 16'h0, 3'(i), 1'b1, 3'(7 - i), 1'b1);
        repeat (10) tick();
        check("rst_no_beats", 32'(exp_d.size()), 32'h0);
        check("rd_a_drained", 32'(exp_a.size()), 32'h0);
        check("rd_b_drained", 32'(exp_b.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_WIDTH, 16: width in bits of every register and data port.
REQ-002 Parameter NUM_REGS, 8: number of registers.
REQ-003 Parameter ADDR_WIDTH, 3: address width, equal to log2(NUM_REGS).
REQ-004 Parameter RESET_VALUE, 0: value loaded into every register on reset.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 Port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port wr_en, input, 1: write strobe.
REQ-009 Port wr_addr, input, ADDR_WIDTH: write address.
REQ-010 Port wr_data, input, DATA_WIDTH: write data.
REQ-011 Port rd_addr_a, input, ADDR_WIDTH: read port A address.
REQ-012 Port rd_data_a, output, DATA_WIDTH: read port A data, registered.
REQ-013 Port rd_addr_b, input, ADDR_WIDTH: read port B address.
REQ-014 Port rd_data_b, output, DATA_WIDTH: read port B data, registered.
REQ-015 Port dump_start, input, 1: request a sequential readout of all registers.
REQ-016 Port dump_busy, output, 1: high while a dump is in progress.
REQ-017 Port dump_valid, output, 1: a dump beat is presented.
REQ-018 Port dump_ready, input, 1: the consumer accepts the current beat.
REQ-019 Port dump_addr, output, ADDR_WIDTH: index of the current beat.
REQ-020 Port dump_data, output, DATA_WIDTH: contents of the register at the current beat.

Function
REQ-021 When wr_en=1 at a rising edge, the block SHALL set reg[wr_addr] to wr_data; when wr_en=0, no register SHALL change.
REQ-022 The read ports SHALL have a latency of 1 cycle: rd_data_x in cycle N+1 SHALL equal reg[rd_addr_x] as sampled in cycle N.
REQ-023 On a read-during-write, meaning wr_en=1 and wr_addr=rd_addr_x in the same cycle, rd_data_x SHALL return the new wr_data (write-first forwarding).
REQ-024 Ports A and B SHALL be independent; both SHALL be able to read the same address in the same cycle.
REQ-025 The dump FSM SHALL have two states: IDLE and SEND.
REQ-026 IDLE to SEND: on dump_start=1, the FSM SHALL set idx=0 and capture reg[0] into dump_data, with that cycle's write forwarded.
REQ-027 In SEND, dump_busy=1, dump_valid=1 and dump_addr=idx.
REQ-028 dump_data and dump_addr SHALL hold stable while dump_valid=1 and dump_ready=0, even if the captured register is rewritten.
REQ-029 A transfer occurs when dump_valid and dump_ready are both high at a rising edge; if idx<NUM_REGS-1, then idx SHALL increment and the FSM SHALL capture reg[idx+1] in the same edge, with forwarding, giving back-to-back beats at 1 beat per cycle.
REQ-030 On the transfer at idx=NUM_REGS-1, the FSM SHALL return to IDLE, and dump_valid and dump_busy SHALL fall in the next cycle.
REQ-031 dump_start while in SEND SHALL be ignored, with no restart and no queuing.
REQ-032 dump_ready while in IDLE SHALL be ignored.
REQ-033 Each dump SHALL deliver exactly NUM_REGS beats, in ascending address order, with no wrap-around.

Reset
REQ-034 On reset, all registers SHALL take RESET_VALUE, rd_data_a=rd_data_b=0, the FSM SHALL enter IDLE, idx=0, dump_valid=dump_busy=0, dump_addr=0 and dump_data=0.
REQ-035 Reset SHALL take priority over wr_en and dump_start in the same cycle.
REQ-036 Reset during SEND SHALL abort the dump; no further beats SHALL appear until a new dump_start.

Verification
REQ-037 Reset, then read all 8 addresses on both ports -> every rd_data equals 0x0000 one cycle after its address.
REQ-038 Write 0xBEEF to reg 5 while rd_addr_a=5 in the same cycle -> rd_data_a=0xBEEF next cycle, and rd_data_b of a later read of reg 5 = 0xBEEF.
REQ-039 Set reg[i]=0x1000+i, pulse dump_start with dump_ready held at 1 -> 8 consecutive beats, addr 0..7, data 0x1000..0x1007, then dump_busy=0.
REQ-040 During a dump, drop dump_ready at beat 3 for 4 cycles and write 0xAAAA to reg 3 meanwhile -> beat 3 holds data 0x1003, addr 3 stable, then beats resume.
REQ-041 Pulse dump_start again at beat 2 -> ignored; exactly 8 beats total.
REQ-042 Assert reset at beat 4 -> dump_valid=0 next cycle, all registers read 0x0000, no beat until a new dump_start.
